spi_slave_rx_shift: RTL and testbench
=====================================

# spi_slave_rx_shift

Receive-side shift engine of the SPI slave, the counterpart of the slave transmit path. It samples the serial input lines on `sclk` and assembles words of a programmable length, shifting 1 bit per edge in single mode or 4 bits per edge in quad mode. Each completed word is presented on a stable output register together with a one-cycle valid pulse. It sits between the SPI pads and the slave controller FSM, which decodes commands, addresses and write data from the words it produces.

## Interface
Parameters:
- none; all widths come from `spi_slave_pkg`.

Ports (one clock; reset is asynchronous and active-high):
- `sclk`  input  1  SPI clock; all state updates on its rising edge.
- `cs`  input  1  chip select, used as the async active-high reset; high = deselected and in reset.
- `sdi0`  input  1  serial data in, lane 0 (MOSI in single mode).
- `sdi1`..`sdi3`  input  1 each  quad data lanes 1–3.
- `en_quad_in`  input  1  1 = quad mode, 0 = single mode; sampled on each edge.
- `counter_in`  input  8  new word-length target, expressed in shift edges minus 1.
- `counter_in_upd`  input  1  load `counter_in` into the target register.
- `data`  output  32  last completed word; stable between completions.
- `data_ready`  output  1  one-cycle pulse, high in the cycle after a word completes.

## Operation
- Internal state:
  - `counter` (8b): shift edges taken so far in the current word.
  - `counter_trgt` (8b): word-length target.
  - `data_int` (32b): shift register.
  - `data` (32b): output register.
  - `data_ready`: output flag.
- On every rising `sclk` edge while `cs` is low:
  - Single mode: `data_int` becomes `{data_int[30:0], sdi0}`.
  - Quad mode: `data_int` becomes `{data_int[27:0], sdi3, sdi2, sdi1, sdi0}`.
- Word completion:
  - Condition: `counter >= counter_trgt`, evaluated before the increment.
  - Effect: `data` takes the shifted value, `data_ready` is set to 1, `counter` goes to 0, `data_int` clears to 0.
  - Otherwise: `counter` increments and `data_ready` is set to 0.
- Words shorter than the shift-register width therefore appear right-aligned and zero-extended in `data`.
- `counter_in_upd` high on an edge: `counter_trgt` takes `counter_in`. `counter` is not affected.
- There is no backpressure. Each completion overwrites `data` unconditionally, so the consumer must capture it within the `data_ready` cycle or before the next completion.

## Timing
- Reset (`cs` high, asynchronous) sets:
  - `counter` = 0
  - `counter_trgt` = 7 (8-bit command byte in single mode)
  - `data_int` = 0
  - `data` = 0
  - `data_ready` = 0
- Latency: `data` and `data_ready` update on the same edge that samples the last bit.
  - Single mode: completion at edge `counter_trgt`+1.
  - Quad mode with target 7: full 32-bit word after 8 edges.
- Consecutive words stream back-to-back. Completion is followed immediately by the first bit of the next word, with no idle edge.
- Simultaneous `counter_in_upd` and completion: completion uses the old target, and the new target governs the next word.
- `counter_in_upd` mid-word: the new target applies from the next edge. If the new target is ≤ the current `counter`, the word completes on that next edge (`>=` compare).
- Mode change mid-word: the new lane width applies from the next edge. Words mixing single and quad edges are legal.
- `cs` rising mid-word: the partial word is discarded and all state returns to reset values. No `data_ready` is produced.
- Target 255: 256 edges per word; the counter never overflows because it clears at completion.

## Configuration
- `SPI_SLAVE_RX_QUAD_EN` defined: quad shifting is implemented as described.
- Macro undefined:
  - Quad logic is compiled out and only the single-mode shift exists.
  - `sdi1`..`sdi3` and `en_quad_in` remain as ports but are ignored.
  - Behaviour is then identical to `en_quad_in` = 0.

## Structure
- `spi_slave_pkg` holds:
  - `SPI_WORD_W` = 32
  - `SPI_CNT_W` = 8
  - `SPI_CNT_TRGT_RST` = 7
  - `SPI_QUAD_LANES` = 4
- No sub-module: one next-state combinational block and one async-reset register block.

## Test plan
- Reset then single mode, shift 8 bits 0xA5 MSB-first -> `data` = 0x000000A5, `data_ready` high for exactly one cycle after edge 8.
- `counter_in` = 31 with upd, shift 0xDEADBEEF -> `data` = 0xDEADBEEF after 32 edges; a second word streams back-to-back with ready again 32 edges later.
- Quad mode, target 7, nibbles 1..8 -> `data` = 0x12345678 after 8 edges.
- `cs` raised after 5 bits, then lowered and 8 bits 0x3C shifted -> no ready during the aborted word; `data` = 0x0000003C; reset values are checked while `cs` is high.
- upd to 3 on the same edge as the completion of an 8-bit word -> that word completes at 8 bits, and the next word completes after 4 edges.
- Macro undefined, `en_quad_in` = 1 with toggling `sdi1`..`sdi3` -> result identical to single mode on `sdi0`.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
// Shared widths and reset constants for the SPI slave receive/transmit paths.
// No ports; imported by spi_slave_rx_shift.
package spi_slave_pkg;

  localparam int SPI_WORD_W       = 32;
  localparam int SPI_CNT_W        = 8;
  localparam int SPI_QUAD_LANES   = 4;

  // Default word length after reset: an 8-bit command byte in single mode.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_TRGT_RST = 8'd7;

endpackage

// File: rtl/spi_slave_rx_shift.sv
// spi_slave_rx_shift
// Receive-side shift engine of the SPI slave. Samples sdi lanes on the rising
// edge of sclk and assembles words of programmable length (1 bit per edge in
// single mode, 4 bits per edge in quad mode). Each completed word is held in
// data with a one-cycle data_ready pulse.
//
// Build option: SPI_SLAVE_RX_QUAD_EN -- when defined, quad shifting is built;
// when undefined only single-mode shifting exists and sdi1..sdi3/en_quad_in
// are ignored.
//
// Ports:
//   sclk            in   SPI clock, all state updates on rising edge
//   cs              in   chip select, async active-high reset (high = idle)
//   sdi0..sdi3      in   serial data lanes (sdi0 = MOSI in single mode)
//   en_quad_in      in   1 = quad mode, 0 = single mode
//   counter_in      in   [7:0] new target, in shift edges minus 1
//   counter_in_upd  in   load counter_in into the target register
//   data            out  [31:0] last completed word
//   data_ready      out  one-cycle pulse after a word completes
module spi_slave_rx_shift
  import spi_slave_pkg::*;
(
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  sdi0,
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic                  en_quad_in,
  input  logic [SPI_CNT_W-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [SPI_WORD_W-1:0] data,
  output logic                  data_ready
);

  logic [SPI_CNT_W-1:0]  counter, counter_nxt;
  logic [SPI_CNT_W-1:0]  counter_trgt, counter_trgt_nxt;
  logic [SPI_WORD_W-1:0] data_int, data_int_nxt;
  logic [SPI_WORD_W-1:0] data_nxt;
  logic                  data_ready_nxt;
  logic [SPI_WORD_W-1:0] shifted;

`ifdef SPI_SLAVE_RX_QUAD_EN
  always_comb begin
    if (en_quad_in)
      shifted = {data_int[SPI_WORD_W-SPI_QUAD_LANES-1:0], sdi3, sdi2, sdi1, sdi0};
    else
      shifted = {data_int[SPI_WORD_W-2:0], sdi0};
  end
`else
  // Quad lanes stay on the port list so the pad wiring is build-independent.
  logic unused_quad;
  assign unused_quad = ^{sdi1, sdi2, sdi3, en_quad_in};

  always_comb begin
    shifted = {data_int[SPI_WORD_W-2:0], sdi0};
  end
`endif

  always_comb begin
    counter_nxt      = counter;
    data_int_nxt     = data_int;
    data_nxt         = data;
    data_ready_nxt   = 1'b0;
    // A new target takes effect from the next edge; the compare below still
    // uses the current one, so a simultaneous completion honours the old target.
    counter_trgt_nxt = counter_in_upd ? counter_in : counter_trgt;

    // >= rather than == so that a target lowered below the current count
    // still terminates the word on the following edge.
    if (counter >= counter_trgt) begin
      data_nxt       = shifted;
      data_ready_nxt = 1'b1;
      counter_nxt    = '0;
      data_int_nxt   = '0;
    end else begin
      counter_nxt    = counter + 1'b1;
      data_int_nxt   = shifted;
    end
  end

  always_ff @(posedge sclk or posedge cs) begin
    if (cs) begin
      counter      <= '0;
      counter_trgt <= SPI_CNT_TRGT_RST;
      data_int     <= '0;
      data         <= '0;
      data_ready   <= 1'b0;
    end else begin
      counter      <= counter_nxt;
      counter_trgt <= counter_trgt_nxt;
      data_int     <= data_int_nxt;
      data         <= data_nxt;
      data_ready   <= data_ready_nxt;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_shift.sv
// tb_spi_slave_rx_shift
// Directed bench for spi_slave_rx_shift. Inputs change on the falling edge of
// sclk; outputs are sampled 1 ns after the rising edge.
module tb_spi_slave_rx_shift;

  logic        sclk;
  logic        cs;
  logic        sdi0, sdi1, sdi2, sdi3;
  logic        en_quad_in;
  logic [7:0]  counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_ready;

  int n_checks = 0;
  int n_err    = 0;

  spi_slave_rx_shift dut (
    .sclk           (sclk),
    .cs             (cs),
    .sdi0           (sdi0),
    .sdi1           (sdi1),
    .sdi2           (sdi2),
    .sdi3           (sdi3),
    .en_quad_in     (en_quad_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_ready     (data_ready)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one word, edge by edge. In quad mode edge i carries nibble
  // stim[4*(edges-1-i) +: 4]; in single mode sdi0 carries stim[edges-1-i]
  // and the unused lanes toggle randomly. upd_edge selects which edge (if
  // any, -1 = none) carries counter_in_upd with upd_val.
  // complete=1: expect ready only after the last edge and data == exp.
  // complete=0: expect no ready on any edge.
  task automatic shift_word(input string tag, input logic [31:0] stim,
                            input int edges, input logic quad,
                            input int upd_edge, input logic [7:0] upd_val,
                            input logic [31:0] exp, input logic complete);
    int early;
    early = 0;
    for (int i = 0; i < edges; i++) begin
      @(negedge sclk);
      en_quad_in = quad;
      if (quad) begin
        {sdi3, sdi2, sdi1, sdi0} = stim[4*(edges-1-i) +: 4];
      end else begin
        sdi0 = stim[edges-1-i];
        {sdi3, sdi2, sdi1} = 3'($urandom);
      end
      counter_in_upd = (i == upd_edge);
      counter_in     = upd_val;
      @(posedge sclk);
      #1;
      if ((i < edges-1 || !complete) && data_ready) early++;
    end
    check_val({tag, "_early_ready"}, early, 0);
    if (complete) begin
      check_val({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
      check_val({tag, "_data"}, data, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_quad;
`ifdef SPI_SLAVE_RX_QUAD_EN
    exp_quad = 32'h12345678;
`else
    // Nibbles 1..8 reduced to their lane-0 bits: 1,0,1,0,1,0,1,0.
    exp_quad = 32'h000000AA;
`endif
    cs = 1'b1;
    sdi0 = 1'b0; sdi1 = 1'b0; sdi2 = 1'b0; sdi3 = 1'b0;
    en_quad_in = 1'b0;
    counter_in = 8'd0;
    counter_in_upd = 1'b0;

    repeat (2) @(posedge sclk);
    #1;
    check_val("rst_data", data, 32'h0);
    check_val("rst_ready", {31'd0, data_ready}, 32'd0);

    @(posedge sclk); #1 cs = 1'b0;

    shift_word("a5", 32'hA5, 8, 1'b0, -1, 8'd0, 32'h000000A5, 1'b1);
    shift_word("deadbeef", 32'hDEADBEEF, 32, 1'b0, 0, 8'd31, 32'hDEADBEEF, 1'b1);
    shift_word("stream", 32'h12345678, 32, 1'b0, -1, 8'd0, 32'h12345678, 1'b1);
    shift_word("quad", 32'h12345678, 8, 1'b1, 0, 8'd7, exp_quad, 1'b1);
    // Update on the completing edge: this word still uses 8 bits, next uses 4.
    shift_word("upd_done", 32'h5A, 8, 1'b0, 7, 8'd3, 32'h0000005A, 1'b1);
    shift_word("short4", 32'hB, 4, 1'b0, -1, 8'd0, 32'h0000000B, 1'b1);
    // Partial word with target raised to 15; abort after 5 bits.
    shift_word("abort", 32'h15, 5, 1'b0, 0, 8'd15, 32'h0, 1'b0);

    @(negedge sclk);
    cs = 1'b1;
    counter_in_upd = 1'b0;
    #1;
    check_val("abort_rst_data", data, 32'h0);
    check_val("abort_rst_ready", {31'd0, data_ready}, 32'd0);
    repeat (2) @(posedge sclk);
    #1;
    check_val("abort_hold_data", data, 32'h0);
    cs = 1'b0;

    // Target must be back at its reset value of 7 (8 edges).
    shift_word("after_abort", 32'h3C, 8, 1'b0, -1, 8'd0, 32'h0000003C, 1'b1);
    // Target lowered to 2 on edge 5 while counter is already 4 -> done on edge 6.
    shift_word("shrink", 32'h2D, 6, 1'b0, 4, 8'd2, 32'h0000002D, 1'b1);
    shift_word("tail", 32'h3, 3, 1'b0, -1, 8'd0, 32'h00000003, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
